// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types and sizing helpers for the perceptron test harness
// Purpose : FSM state encoding for the pattern sequencer plus the frame-length
//           and balance-width helpers shared with the network and output stage.
// Ports   : none (package).
package snn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET_NET,
        S_RUN,
        S_SAMPLE,
        S_DONE
    } state_t;

    // Each pixel slot needs 2**(width+1) counting cycles plus two cycles of overhead.
    function automatic int frame_cycles(input int width, input int height);
        return height * ((2 ** (width + 1)) + 2);
    endfunction

    // Balance can reach height * (2**width - 1), so it needs enough bits for that value.
    function automatic int bal_width(input int width, input int height);
        return $clog2(height * ((2 ** width) - 1) + 1);
    endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - loadable down-counter with terminal-count flag
// Purpose : times the network-reset and evaluation intervals of each frame.
// Ports   : clk, rst (sync, active-high), i_load/i_len load a new interval,
//           o_tc is high during the last cycle of the loaded interval.
module frame_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_len,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_len;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // A load of N makes the interval last N cycles; count N..1, so 1 marks the last one.
    assign o_tc = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - drives test patterns into the network and scores its answers
// Purpose : steps through PATTERNS, holding each on the pixel inputs for one
//           evaluation frame, pulses the network reset between frames and
//           captures/scores the neuron output at the end of each frame.
// Ports   : clk, rst (sync, active-high), start;
//           pixels, net_rst_n to the network; neuron_in, balance_in from it;
//           busy, done, result_valid, result_idx, result_class,
//           result_balance, result_match, correct_cnt status/results.
module pattern_sequencer
    import snn_pkg::*;
#(
    parameter int                     WIDTH        = 8,
    parameter int                     HEIGHT       = 7,
    parameter int                     NUM_PATTERNS = 4,
    parameter logic [HEIGHT-1:0]      PATTERNS [NUM_PATTERNS] =
        '{7'b0001110, 7'b1110000, 7'b0000000, 7'b1111111},
    parameter logic [NUM_PATTERNS-1:0] LABELS      = 4'b1001,
    parameter int                     RST_CYCLES   = 2,
    parameter int                     FRAME_CYCLES = frame_cycles(WIDTH, HEIGHT),
    parameter int                     BAL_W        = bal_width(WIDTH, HEIGHT),
    localparam int                    IDX_W        = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
    localparam int                    CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [HEIGHT-1:0] pixels,
    output logic              net_rst_n,
    input  logic              neuron_in,
    input  logic [BAL_W-1:0]  balance_in,
    output logic              busy,
    output logic              done,
    output logic              result_valid,
    output logic [IDX_W-1:0]  result_idx,
    output logic              result_class,
    output logic [BAL_W-1:0]  result_balance,
    output logic              result_match,
    output logic [CNT_W-1:0]  correct_cnt
);

    localparam int TMR_MAX = (FRAME_CYCLES > RST_CYCLES) ? FRAME_CYCLES : RST_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_next;
    logic              w_tc;
    logic              w_tmr_load;
    logic [TMR_W-1:0]  w_tmr_len;
    logic              w_match;
    logic              w_busy_next;
    logic              w_start_seq;
    logic              w_capture;

    logic [HEIGHT-1:0] r_pixels;
    logic              r_net_rst_n;
    logic              r_busy;
    logic              r_done;
    logic              r_result_valid;
    logic [IDX_W-1:0]  r_result_idx;
    logic              r_result_class;
    logic [BAL_W-1:0]  r_result_balance;
    logic              r_result_match;
    logic [CNT_W-1:0]  r_correct_cnt;

    frame_timer #(.CNT_W(TMR_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_tmr_load),
        .i_len  (w_tmr_len),
        .o_tc   (w_tc)
    );

    assign w_match     = (neuron_in == LABELS[r_idx]);
    assign w_start_seq = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    assign w_capture   = (r_state == S_RUN) && w_tc;
    assign w_busy_next = (w_state_next == S_RESET_NET) || (w_state_next == S_RUN) ||
                         (w_state_next == S_SAMPLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Timer is reloaded on every transition into a timed state.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_tmr_load   = 1'b0;
        w_tmr_len    = TMR_W'(RST_CYCLES);
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = S_RESET_NET;
                    w_idx_next   = '0;
                    w_tmr_load   = 1'b1;
                end
            end
            S_RESET_NET: begin
                if (w_tc) begin
                    w_state_next = S_RUN;
                    w_tmr_load   = 1'b1;
                    w_tmr_len    = TMR_W'(FRAME_CYCLES);
                end
            end
            S_RUN: begin
                if (w_tc) begin
                    w_state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (r_idx == LAST_IDX) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_RESET_NET;
                    w_idx_next   = r_idx + 1'b1;
                    w_tmr_load   = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx            <= '0;
            r_pixels         <= '0;
            r_net_rst_n      <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_result_valid   <= 1'b0;
            r_result_idx     <= '0;
            r_result_class   <= 1'b0;
            r_result_balance <= '0;
            r_result_match   <= 1'b0;
            r_correct_cnt    <= '0;
        end else begin
            r_idx          <= w_idx_next;
            r_pixels       <= w_busy_next ? PATTERNS[w_idx_next] : '0;
            r_net_rst_n    <= (w_state_next == S_RUN) || (w_state_next == S_SAMPLE);
            r_busy         <= w_busy_next;
            r_done         <= (w_state_next == S_DONE);
            r_result_valid <= w_capture;
            if (w_capture) begin
                r_result_idx     <= r_idx;
                r_result_class   <= neuron_in;
                r_result_balance <= balance_in;
                r_result_match   <= w_match;
                r_correct_cnt    <= r_correct_cnt + CNT_W'(w_match);
            end else if (w_start_seq) begin
                r_correct_cnt <= '0;
            end
        end
    end

    assign pixels         = r_pixels;
    assign net_rst_n      = r_net_rst_n;
    assign busy           = r_busy;
    assign done           = r_done;
    assign result_valid   = r_result_valid;
    assign result_idx     = r_result_idx;
    assign result_class   = r_result_class;
    assign result_balance = r_result_balance;
    assign result_match   = r_result_match;
    assign correct_cnt    = r_correct_cnt;

endmodule
